wide_add_sequencer: RTL
=======================

// Module: wide_add_sequencer
// PURPOSE
//  Multi-cycle add/subtract controller that reuses one CHUNK_W-bit ripple adder to compute a
//  CHUNK_W*N_CHUNKS-bit result, one chunk per cycle, LSB chunk first. It sits between the ALU
//  op decoder (start handshake) and the shared small adder (add_* ports), and returns the
//  result, carry and signed overflow over a valid/ready result handshake.
// PARAMETERS
//  CHUNK_W   6  width of the external ripple adder
//  N_CHUNKS  4  chunks per operation; W = CHUNK_W*N_CHUNKS = 24
// PORTS
//  clk          in   1        single clock, rising edge
//  reset        in   1        synchronous, active-high
//  start_valid  in   1        operation request
//  start_ready  out  1        high only in IDLE
//  op_sub       in   1        0 = a+b, 1 = a-b; sampled on accept
//  a            in   W        operand A; sampled on accept
//  b            in   W        operand B; sampled on accept
//  add_x        out  CHUNK_W  adder operand x (A chunk)
//  add_y        out  CHUNK_W  adder operand y (B chunk, inverted if sub)
//  add_cin      out  1        adder carry in
//  add_sum      in   CHUNK_W  adder sum, combinational, same cycle
//  add_cout     in   1        adder carry out, combinational, same cycle
//  res_valid    out  1        result available
//  res_ready    in   1        result consumer ready
//  result       out  W        sum/difference, modulo 2^W
//  carry_out    out  1        final carry; for sub 1 = no borrow (a >= b unsigned)
//  overflow     out  1        signed two's-complement overflow
//  busy         out  1        high in RUN or DONE
// BEHAVIOUR
//  - FSM: IDLE -> RUN on accept (start_valid & start_ready); RUN -> DONE after N_CHUNKS
//    chunk cycles; DONE -> IDLE on res_valid & res_ready. No other transitions.
//  - Accept edge: latch a, b' = op_sub ? ~b : b, carry reg = op_sub, chunk idx = 0.
//  - RUN cycle idx: add_x = a[idx*CHUNK_W +: CHUNK_W], add_y = b'[same], add_cin = carry reg.
//    On the edge: result chunk idx <= add_sum; carry reg <= add_cout; idx++.
//    The controller relies only on add_sum/add_cout, never on the adder's own overflow output.
//  - Outside RUN, add_x, add_y and add_cin are driven 0.
//  - The edge that captures chunk N_CHUNKS-1 moves the FSM to DONE, so res_valid rises
//    exactly N_CHUNKS edges after the accepting edge.
//  - carry_out = final carry reg.
//  - overflow = (a[W-1] == b'[W-1]) & (result[W-1] != a[W-1]).
//  - DONE: res_valid = 1. result, carry_out and overflow hold stable until the res handshake.
//    start_ready = 0, so start_valid is ignored.
//  - After the res handshake: one IDLE cycle (start_ready = 1) before the next accept can occur.
//    The minimum issue interval is N_CHUNKS + 2 cycles.
//  - result, carry_out and overflow keep their last values in IDLE. They are valid only while
//    res_valid = 1.
//  - Reset (any state, including mid-RUN or DONE): next state IDLE and the operation is aborted
//    with no result.
//    All outputs reset to 0 except start_ready = 1. Internal idx, carry and operand regs reset to 0.
//  - Operands are registered at accept, so changes on a/b/op_sub during RUN have no effect.
// TESTING
//  1 add 0x000FFF + 0x000001 -> result 0x001000, carry_out 0, overflow 0.
//    add_cin per RUN cycle = 0,1,1,0. res_valid exactly 4 edges after accept.
//  2 sub 0x000000 - 0x000001 -> result 0xFFFFFF, carry_out 0 (borrow), overflow 0.
//    First add_cin = 1, add_y chunk0 = 0x3E.
//  3 add 0x7FFFFF + 0x000001 -> result 0x800000, overflow 1, carry_out 0.
//    add 0xFFFFFF + 0x000001 -> result 0x000000, carry_out 1, overflow 0.
//  4 sub 0x800000 - 0x000001 -> result 0x7FFFFF, overflow 1, carry_out 1.
//  5 Backpressure: hold res_ready = 0 for 5 cycles after res_valid, pulsing start_valid.
//    Required: result/flags stable, start_ready = 0, no new accept.
//    After res_ready = 1: one IDLE cycle, then the next op is accepted.
//  6 Reset mid-RUN: reset high during the 2nd RUN cycle.
//    Next cycle: IDLE, start_ready 1, res_valid 0, busy 0, add_* = 0.
//    A following add 0x000005 + 0x000003 -> result 0x000008.

Source files
------------

// File: rtl/wide_add_sequencer.sv
// Multi-cycle wide add/subtract controller driving a shared narrow ripple adder,
// one chunk per cycle, LSB chunk first, with start and result handshakes.
module wide_add_sequencer #(
    parameter int CHUNK_W  = 6,
    parameter int N_CHUNKS = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start_valid,
    output logic                          start_ready,
    input  logic                          op_sub,
    input  logic [CHUNK_W*N_CHUNKS-1:0]   a,
    input  logic [CHUNK_W*N_CHUNKS-1:0]   b,
    output logic [CHUNK_W-1:0]            add_x,
    output logic [CHUNK_W-1:0]            add_y,
    output logic                          add_cin,
    input  logic [CHUNK_W-1:0]            add_sum,
    input  logic                          add_cout,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [CHUNK_W*N_CHUNKS-1:0]   result,
    output logic                          carry_out,
    output logic                          overflow,
    output logic                          busy
);

    localparam int W     = CHUNK_W * N_CHUNKS;
    localparam int IDX_W = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     result_q, result_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        add_x    = '0;
        add_y    = '0;
        add_cin  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_valid) begin
                    // Subtraction is a + ~b + 1; the +1 enters as the first carry.
                    a_d     = a;
                    b_d     = op_sub ? ~b : b;
                    carry_d = op_sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < N_CHUNKS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        add_x = a_q[i*CHUNK_W +: CHUNK_W];
                        add_y = b_q[i*CHUNK_W +: CHUNK_W];
                        result_d[i*CHUNK_W +: CHUNK_W] = add_sum;
                    end
                end
                add_cin = carry_q;
                carry_d = add_cout;
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign start_ready = (state_q == IDLE);
    assign res_valid   = (state_q == DONE);
    assign busy        = (state_q == RUN) || (state_q == DONE);
    assign result      = result_q;
    assign carry_out   = carry_q;
    assign overflow    = (a_q[W-1] == b_q[W-1]) && (result_q[W-1] != a_q[W-1]);

endmodule
